bus_slave_ram: RTL



---
 rtl/bus_slave_ram_pkg.sv | 30 +++
 rtl/bus_slave_ram_if.sv | 11 +
 rtl/bus_slave_ram_mem.sv | 39 +++
 rtl/bus_slave_ram.sv | 112 +++++++++++
 4 files changed

// File: rtl/bus_slave_ram_pkg.sv
// rtl/bus_slave_ram_pkg.sv - bus request/response structs, FSM states and wait limit
package bus_slave_ram_pkg;

  localparam int BUS_MAX_WAIT = 15;

  // Master-to-slave request
  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] data;
    logic [29:0] addr;
  } m2s_s;

  // Slave-to-master response
  typedef struct packed {
    logic [31:0] data;
    logic        ack;
    logic        stall;
    logic        err;
  } s2m_s;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } bus_slv_state_e;

endpackage

// File: rtl/bus_slave_ram_if.sv
// rtl/bus_slave_ram_if.sv - request/response pair between a bus master and a slave
interface bus_slave_ram_if;
  import bus_slave_ram_pkg::*;

  m2s_s bus_i;
  s2m_s bus_o;

  modport master (output bus_i, input bus_o);
  modport slave  (input bus_i, output bus_o);

endinterface

// File: rtl/bus_slave_ram_mem.sv
// rtl/bus_slave_ram_mem.sv - DEPTH_WORDS x 32 synchronous RAM, byte enables, write-first
module bus_slave_ram_mem #(
  parameter int DEPTH_WORDS = 1024,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rdata;
  logic [31:0] w_merged;

  // Word as it will look after this cycle's write; returned on a same-index read
  always_comb begin
    w_merged = r_mem[idx];
    for (int b = 0; b < 4; b++) begin
      if (we && be[b]) begin
        w_merged[8*b +: 8] = wdata[8*b +: 8];
      end
    end
  end

  // Commit enabled bytes and register the read word (one-cycle latency)
  always_ff @(posedge clk) begin
    if (en) begin
      r_mem[idx] <= w_merged;
      r_rdata    <= w_merged;
    end
  end

  assign rdata = r_rdata;

endmodule

// File: rtl/bus_slave_ram.sv
// rtl/bus_slave_ram.sv - bus slave fronting a word RAM with wait states and decode error
module bus_slave_ram
  import bus_slave_ram_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [29:0] BASE_ADDR   = 30'h0,
  parameter int          WAIT_STATES = 0
) (
  input logic            clk,
  input logic            rst,
  bus_slave_ram_if.slave bus
);

  localparam int          AW     = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WS     = 4'(WAIT_STATES);
  // 31-bit range bounds so BASE_ADDR+DEPTH_WORDS at the top of the map does not wrap
  localparam logic [30:0] BASE31 = {1'b0, BASE_ADDR};
  localparam logic [30:0] TOP31  = BASE31 + 31'(DEPTH_WORDS);

  bus_slv_state_e r_state;
  bus_slv_state_e w_state_nx;
  logic [3:0]     r_cnt;
  logic [3:0]     w_cnt_nx;
  logic           r_hit;
  logic           r_we;

  logic [30:0]    w_addr31;
  logic           w_hit;
  logic [AW-1:0]  w_idx;
  logic           w_stall;
  logic           w_accept;
  logic           w_resp;
  logic [31:0]    w_rdata;

  assign w_addr31 = {1'b0, bus.bus_i.addr};
  assign w_hit    = (w_addr31 >= BASE31) && (w_addr31 < TOP31);
  assign w_idx    = AW'(w_addr31 - BASE31);

  assign w_stall  = (r_state == WAIT);
  assign w_accept = bus.bus_i.cyc && bus.bus_i.stb && !w_stall;
  assign w_resp   = (r_state == RESP);

  bus_slave_ram_mem #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_mem (
    .clk  (clk),
    .en   (w_accept && w_hit && !rst),
    .we   (bus.bus_i.we),
    .be   (bus.bus_i.sel),
    .idx  (w_idx),
    .wdata(bus.bus_i.data),
    .rdata(w_rdata)
  );

  // Next state: accept from IDLE/RESP, count wait states, drop pending response on cyc loss
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    case (r_state)
      IDLE, RESP: begin
        if (w_accept) begin
          if (WS == 4'd0) begin
            w_state_nx = RESP;
          end else begin
            w_state_nx = WAIT;
            w_cnt_nx   = WS - 4'd1;
          end
        end else begin
          w_state_nx = IDLE;
        end
      end
      WAIT: begin
        if (!bus.bus_i.cyc) begin
          w_state_nx = IDLE;
          w_cnt_nx   = 4'd0;
        end else if (r_cnt == 4'd0) begin
          w_state_nx = RESP;
        end else begin
          w_cnt_nx   = r_cnt - 4'd1;
        end
      end
      default: begin
        w_state_nx = IDLE;
        w_cnt_nx   = 4'd0;
      end
    endcase
  end

  // State, counter and per-access decode result captured at accept
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_hit   <= 1'b0;
      r_we    <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      if (w_accept) begin
        r_hit <= w_hit;
        r_we  <= bus.bus_i.we;
      end
    end
  end

  // The RAM output register holds the read word until the response cycle (en only on accept)
  assign bus.bus_o.ack   = w_resp && r_hit;
  assign bus.bus_o.err   = w_resp && !r_hit;
  assign bus.bus_o.stall = w_stall;
  assign bus.bus_o.data  = (w_resp && r_hit && !r_we) ? w_rdata : 32'h0;

endmodule
